// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the sequential multiply/accumulate slice.
//   state_t            - accumulator FSM states (ACCUM, FULL)
//   PRODUCT_LENGTH_DEF - default product width (seq_mult A+B widths)
//   GROUP_COUNT_DEF    - default number of products summed per result
//   acc_width()        - sum width that cannot overflow for a given group size
package seq_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned PRODUCT_LENGTH_DEF = 7;
    localparam int unsigned GROUP_COUNT_DEF    = 4;

    function automatic int unsigned acc_width(input int unsigned product_length,
                                              input int unsigned group_count);
        return product_length + $clog2(group_count);
    endfunction

endpackage

// File: rtl/seq_accum_oreg.sv
// seq_accum_oreg: output holding register with valid/ready handshake.
//   clk, rst        - clock, asynchronous active-low reset
//   load, load_data - load strobe and value; load always (re)asserts sum_valid
//   sum, sum_valid  - registered result and its qualifier
//   sum_ready       - downstream accepts sum when sum_valid && sum_ready
module seq_accum_oreg #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    output logic [Width-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else if (load) begin
            // A reload in the same cycle as a consume keeps sum_valid high.
            sum       <= load_data;
            sum_valid <= 1'b1;
        end else if (sum_valid && sum_ready) begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_accum.sv
// seq_accum: sums groups of Group_count products from seq_mult and presents
// each group total through a valid/ready output register. A completed group
// that cannot be handed off is parked in the accumulator (state FULL); any
// product arriving while parked is discarded and flagged in drop_err.
//   clk        - clock, all updates on posedge
//   rst        - asynchronous active-low reset
//   z, z_valid - incoming product and single-cycle qualifier (no backpressure)
//   acc_clr    - synchronous abort of the current partial/parked group
//   sum, sum_valid, sum_ready - result handshake
//   drop_err   - sticky: at least one product was discarded
//   drop_count - (only with SEQ_ACCUM_DROPCNT_EN) saturating discard counter
// Build option: define SEQ_ACCUM_DROPCNT_EN to add drop_count.
module seq_accum
    import seq_pkg::*;
#(
    parameter int unsigned Product_length = PRODUCT_LENGTH_DEF,
    parameter int unsigned Group_count    = GROUP_COUNT_DEF
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [Product_length-1:0]                      z,
    input  logic                                           z_valid,
    input  logic                                           acc_clr,
    output logic [Product_length+$clog2(Group_count)-1:0]  sum,
    output logic                                           sum_valid,
    input  logic                                           sum_ready,
`ifdef SEQ_ACCUM_DROPCNT_EN
    output logic [7:0]                                     drop_count,
`endif
    output logic                                           drop_err
);

    localparam int unsigned Acc_length = acc_width(Product_length, Group_count);
    localparam int unsigned Cnt_length = $clog2(Group_count);
    localparam int unsigned Ext_length = Acc_length - Product_length;
    localparam logic [Cnt_length-1:0] CNT_LAST = Cnt_length'(Group_count - 1);

    state_t                  state;
    state_t                  state_next;
    logic [Acc_length-1:0]   acc;
    logic [Cnt_length-1:0]   cnt;
    logic [Acc_length-1:0]   z_ext;
    logic [Acc_length-1:0]   acc_plus_z;
    logic                    cnt_last;
    logic                    out_free;

    logic                    acc_zero;
    logic                    acc_add;
    logic                    cnt_inc;
    logic                    load;
    logic [Acc_length-1:0]   load_data;
    logic                    drop;

    assign z_ext      = {{Ext_length{1'b0}}, z};
    assign acc_plus_z = acc + z_ext;
    assign cnt_last   = (cnt == CNT_LAST);
    assign out_free   = !sum_valid || sum_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM: begin
                if (!acc_clr && z_valid && cnt_last && !out_free) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (acc_clr || sum_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Datapath control
    always_comb begin
        acc_zero  = 1'b0;
        acc_add   = 1'b0;
        cnt_inc   = 1'b0;
        load      = 1'b0;
        load_data = acc_plus_z;
        drop      = 1'b0;
        unique case (state)
            ACCUM: begin
                if (acc_clr) begin
                    acc_zero = 1'b1;
                end else if (z_valid) begin
                    if (!cnt_last) begin
                        acc_add = 1'b1;
                        cnt_inc = 1'b1;
                    end else if (out_free) begin
                        load      = 1'b1;
                        load_data = acc_plus_z;
                        acc_zero  = 1'b1;
                    end else begin
                        // Park the finished group; cnt stays at CNT_LAST.
                        acc_add = 1'b1;
                    end
                end
            end
            FULL: begin
                // acc_clr outranks the hand-off and silently eats any z.
                if (acc_clr) begin
                    acc_zero = 1'b1;
                end else begin
                    if (sum_ready) begin
                        load      = 1'b1;
                        load_data = acc;
                        acc_zero  = 1'b1;
                    end
                    drop = z_valid;
                end
            end
            default: ;
        endcase
    end

    // Accumulator and product counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (acc_zero) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (acc_add) begin
                acc <= acc_plus_z;
            end
            if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end
    end

`ifdef SEQ_ACCUM_DROPCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    seq_accum_oreg #(
        .Width (Acc_length)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

endmodule

// File: doc/seq_accum.md
SEQ_ACCUM -- requirements
Module: seq_accum

Interface
REQ-001 Parameter Product_length, default 7, width of incoming product z (matches seq_mult Multiplicand_length+Multiplier_length).
REQ-002 Parameter Group_count, default 4, number of products summed per result; legal range 2..256.
REQ-003 Derived constant Acc_length = Product_length + $clog2(Group_count); sum width, overflow-free by construction.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 z  input  Product_length  product from upstream seq_mult.
REQ-007 z_valid  input  1  z qualifier, single-cycle pulse per product; upstream has no backpressure.
REQ-008 acc_clr  input  1  synchronous abort of the current partial group.
REQ-009 sum  output  Acc_length  registered group sum.
REQ-010 sum_valid  output  1  sum holds an unconsumed result.
REQ-011 sum_ready  input  1  downstream accepts sum when sum_valid && sum_ready at posedge.
REQ-012 drop_err  output  1  sticky flag: at least one product was discarded.

Function
REQ-013 FSM states: ACCUM (collecting products) and FULL (completed group parked in accumulator, output register occupied).
REQ-014 ACCUM, z_valid, cnt < Group_count-1: acc <= acc + z, cnt <= cnt + 1.
REQ-015 ACCUM, z_valid, cnt == Group_count-1, output free (sum_valid==0 or sum_ready==1): sum <= acc + z, sum_valid <= 1, acc <= 0, cnt <= 0; sum_valid visible one cycle after the final z_valid edge.
REQ-016 ACCUM, z_valid, cnt == Group_count-1, output occupied and not accepted: acc <= acc + z, go to FULL.
REQ-017 FULL, sum_ready==1: sum <= acc, sum_valid stays 1, acc <= 0, cnt <= 0, go to ACCUM; a z_valid in that same cycle is discarded and sets drop_err.
REQ-018 FULL, any z_valid: product discarded, drop_err <= 1, acc/cnt unchanged.
REQ-019 sum_valid deasserts on sum_valid && sum_ready unless REQ-015/REQ-017 reloads in the same cycle; back-to-back results sustain sum_valid=1.
REQ-020 sum and sum_valid stable while sum_valid && !sum_ready.
REQ-021 acc_clr has priority over z_valid: acc <= 0, cnt <= 0, concurrent z discarded without drop_err; in FULL, acc_clr discards the parked group and returns to ACCUM; output register unaffected.
REQ-022 drop_err clears only on reset.
REQ-023 Arithmetic unsigned; z zero-extended to Acc_length before add; no wrap possible.

Reset
REQ-024 rst low at any time, including mid-group or in FULL: state ACCUM, acc 0, cnt 0, sum 0, sum_valid 0, drop_err 0, immediately and asynchronously.
REQ-025 Deassertion takes effect at the next posedge; a z_valid coincident with that edge is discarded.

Configuration
REQ-026 Macro SEQ_ACCUM_DROPCNT_EN defined: adds output drop_count [7:0], incremented per discarded product (REQ-017/018), saturating at 255, reset to 0.
REQ-027 Macro undefined: port drop_count and its counter are absent; all other behaviour identical.

Structure
REQ-028 Package seq_pkg holds the state enum typedef (ACCUM, FULL), default Product_length/Group_count constants, and an acc-width function shared with seq_mult benches.
REQ-029 One sub-module, seq_accum_oreg: output register with sum/sum_valid/sum_ready handshake and load strobe; FSM and accumulator stay in seq_accum.

Verification (Product_length=7, Group_count=4)
REQ-030 z=10,20,30,40 on four z_valid pulses, sum_ready=1 -> sum=100, sum_valid=1 for one cycle, one cycle after 4th pulse.
REQ-031 z=127 x4 -> sum=508, no drop_err; then z=1 x4 -> sum=4.
REQ-032 sum_ready=0, two groups of 1,1,1,1 then 2,2,2,2, then z=5 -> sum=4 held, FSM in FULL, z=5 dropped, drop_err=1; sum_ready=1 -> sum=8 next cycle, then sum_valid=0.
REQ-033 z=3,3 then acc_clr with concurrent z=9, then z=1 x4 -> sum=4, drop_err=0.
REQ-034 rst low after two of four products and again in FULL -> all outputs 0 asynchronously; next full group sums correctly.
REQ-035 With SEQ_ACCUM_DROPCNT_EN, 300 products while FULL -> drop_count=255, drop_err=1.
